// File: rtl/jtkiwi_pkg.sv
// Shared definitions for the Kiwi shared-RAM arbiter: default geometry,
// FSM state encoding, port identifiers and the priority helper.
package jtkiwi_pkg;

  localparam int SHRAM_AW = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DATA = 2'd2
  } shram_state_t;

  typedef enum logic {
    MAIN = 1'b0,
    SUB  = 1'b1
  } port_t;

  // On a tie the port that was not served most recently wins.
  function automatic port_t pick_port(input logic pend_main, input logic pend_sub,
                                      input port_t last);
    if (pend_main && pend_sub) return (last == MAIN) ? SUB : MAIN;
    return pend_sub ? SUB : MAIN;
  endfunction

endpackage

// File: rtl/jtframe_ram.sv
// Single-port synchronous RAM with a registered read port.
// Write data lands at the clock edge; q shows the addressed word one edge later.
module jtframe_ram #(
  parameter int    AW      = 13,
  parameter int    DW      = 8,
  parameter string SIMFILE = ""
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  input  logic          we,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= data;
    q <= mem[addr];
  end

  // Preloading is left to the simulation environment; hardware starts from the
  // device's power-up contents, so a file name only marks the instance.
  if (SIMFILE != "") begin : g_preload_marker
  end

endmodule

// File: rtl/jtkiwi_shram.sv
// 8 kB RAM shared by the Kiwi main CPU and the sound/sub CPU.
// Alternating-priority arbiter in front of one single-port registered-read RAM.
module jtkiwi_shram
  import jtkiwi_pkg::*;
#(
  parameter int    AW      = SHRAM_AW,
  parameter int    DW      = 8,
  parameter string SIMFILE = ""
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          main_cs,
  input  logic          main_we,
  input  logic [AW-1:0] main_addr,
  input  logic [DW-1:0] main_din,
  output logic [DW-1:0] main_dout,
  output logic          main_busy,
  input  logic          sub_cs,
  input  logic          sub_we,
  input  logic [AW-1:0] sub_addr,
  input  logic [DW-1:0] sub_din,
  output logic [DW-1:0] sub_dout,
  output logic          sub_busy
);

  shram_state_t  state;
  port_t         last;
  port_t         cur;
  port_t         grant;
  logic          main_done;
  logic          sub_done;
  logic          pend_main;
  logic          pend_sub;
  logic [AW-1:0] addr_l;
  logic [DW-1:0] din_l;
  logic          we_l;
  logic [DW-1:0] ram_q;
  logic          ram_we;

  assign pend_main = main_cs & ~main_done;
  assign pend_sub  = sub_cs & ~sub_done;
  assign main_busy = pend_main;
  assign sub_busy  = pend_sub;
  assign grant     = pick_port(pend_main, pend_sub, last);

  // A reset arriving during ACC cancels the write that would land on this edge.
  assign ram_we = (state == ACC) && we_l && !rst;

  jtframe_ram #(
    .AW      (AW),
    .DW      (DW),
    .SIMFILE (SIMFILE)
  ) u_ram (
    .clk  (clk),
    .addr (addr_l),
    .data (din_l),
    .we   (ram_we),
    .q    (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= SUB;
      cur       <= MAIN;
      main_done <= 1'b0;
      sub_done  <= 1'b0;
      main_dout <= '0;
      sub_dout  <= '0;
      addr_l    <= '0;
      din_l     <= '0;
      we_l      <= 1'b0;
    end else begin
      if (!main_cs) main_done <= 1'b0;
      if (!sub_cs)  sub_done  <= 1'b0;

      case (state)
        IDLE: begin
          if (pend_main || pend_sub) begin
            cur <= grant;
            if (grant == SUB) begin
              addr_l <= sub_addr;
              din_l  <= sub_din;
              we_l   <= sub_we;
            end else begin
              addr_l <= main_addr;
              din_l  <= main_din;
              we_l   <= main_we;
            end
            state <= ACC;
          end
        end

        ACC: state <= DATA;

        // Completion wins over the cs-low clear, so a dropped cs still ends served.
        DATA: begin
          if (!we_l) begin
            if (cur == SUB) sub_dout  <= ram_q;
            else            main_dout <= ram_q;
          end
          if (cur == SUB) sub_done  <= 1'b1;
          else            main_done <= 1'b1;
          last  <= cur;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtkiwi_shram.sv
// Self-checking bench for jtkiwi_shram: directed arbitration cases plus a
// randomized two-port run against a behavioural memory model.
module tb_jtkiwi_shram;

  localparam int AW = 13;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          main_cs = 1'b0;
  logic          main_we = 1'b0;
  logic [AW-1:0] main_addr = '0;
  logic [DW-1:0] main_din = '0;
  logic [DW-1:0] main_dout;
  logic          main_busy;
  logic          sub_cs = 1'b0;
  logic          sub_we = 1'b0;
  logic [AW-1:0] sub_addr = '0;
  logic [DW-1:0] sub_din = '0;
  logic [DW-1:0] sub_dout;
  logic          sub_busy;

  int checks = 0;
  int fails  = 0;

  logic [DW-1:0] model_mem   [0:(1<<AW)-1];
  bit            model_known [0:(1<<AW)-1];

  always #5 clk = ~clk;

  jtkiwi_shram #(.AW(AW), .DW(DW), .SIMFILE("")) dut (
    .clk       (clk),
    .rst       (rst),
    .main_cs   (main_cs),
    .main_we   (main_we),
    .main_addr (main_addr),
    .main_din  (main_din),
    .main_dout (main_dout),
    .main_busy (main_busy),
    .sub_cs    (sub_cs),
    .sub_we    (sub_we),
    .sub_addr  (sub_addr),
    .sub_din   (sub_din),
    .sub_dout  (sub_dout),
    .sub_busy  (sub_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic drive(input int p, input logic cs, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      main_cs = cs; main_we = we; main_addr = a; main_din = d;
    end else begin
      sub_cs = cs; sub_we = we; sub_addr = a; sub_din = d;
    end
  endtask

  function automatic logic busy_of(input int p);
    return (p == 0) ? main_busy : sub_busy;
  endfunction

  function automatic logic [DW-1:0] dout_of(input int p);
    return (p == 0) ? main_dout : sub_dout;
  endfunction

  task automatic model_access(input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [DW-1:0] rd);
    if (we) begin
      model_mem[a]   = d;
      model_known[a] = 1'b1;
    end else if (!model_known[a]) begin
      model_mem[a]   = rd;
      model_known[a] = 1'b1;
    end
  endtask

  // One complete access on a single port; cs is dropped for a cycle afterwards.
  task automatic applyStimulus(input int p, input logic we, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, output int lat,
                               output logic [DW-1:0] rd, output bit other_busy);
    drive(p, 1'b1, we, a, d);
    #1;
    lat = 0;
    other_busy = 1'b0;
    while (busy_of(p) && lat < 20) begin
      lat++;
      if (busy_of(1 - p)) other_busy = 1'b1;
      step();
    end
    rd = dout_of(p);
    model_access(we, a, d, rd);
    drive(p, 1'b0, 1'b0, a, d);
    step();
  endtask

  // Both ports raise cs on the same cycle; returns each port's busy length.
  task automatic applyPair(input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                           input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                           output int lat0, output int lat1);
    bit fin0, fin1;
    drive(0, 1'b1, we0, a0, d0);
    drive(1, 1'b1, we1, a1, d1);
    #1;
    lat0 = 0; lat1 = 0; fin0 = 0; fin1 = 0;
    for (int i = 0; i < 14 && !(fin0 && fin1); i++) begin
      if (!fin0) begin
        if (main_busy) lat0++;
        else begin fin0 = 1; model_access(we0, a0, d0, main_dout); end
      end
      if (!fin1) begin
        if (sub_busy) lat1++;
        else begin fin1 = 1; model_access(we1, a1, d1, sub_dout); end
      end
      if (!(fin0 && fin1)) step();
    end
    drive(0, 1'b0, 1'b0, a0, d0);
    drive(1, 1'b0, 1'b0, a1, d1);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    int lat, lat0, lat1, highs, ops, cyc;
    logic [DW-1:0] rd;
    bit ob;
    bit            active [2];
    int            plat   [2];
    logic          we_r   [2];
    logic [AW-1:0] addr_r [2];
    logic [DW-1:0] din_r  [2];
    logic [DW-1:0] held   [2];

    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    checkOutput("reset_main_dout", 32'(main_dout), 32'h0);
    checkOutput("reset_sub_dout",  32'(sub_dout),  32'h0);
    checkOutput("reset_main_busy", 32'(main_busy), 32'h0);
    checkOutput("reset_sub_busy",  32'(sub_busy),  32'h0);

    $display("[TB] sub write then read at 0x0C0A");
    applyStimulus(1, 1'b1, 13'h0C0A, 8'h5A, lat, rd, ob);
    checkOutput("t1_wr_lat", 32'(lat), 32'd3);
    checkOutput("t1_wr_main_busy", 32'(ob), 32'd0);
    checkOutput("t1_wr_dout_kept", 32'(sub_dout), 32'h0);
    applyStimulus(1, 1'b0, 13'h0C0A, 8'h00, lat, rd, ob);
    checkOutput("t1_rd_lat", 32'(lat), 32'd3);
    checkOutput("t1_rd_data", 32'(rd), 32'h5A);
    checkOutput("t1_rd_main_busy", 32'(ob), 32'd0);

    $display("[TB] simultaneous requests after reset");
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    applyPair(1'b0, 13'h0C0A, 8'h00, 1'b0, 13'h0C0A, 8'h00, lat0, lat1);
    checkOutput("t2_tie1_main_lat", 32'(lat0), 32'd3);
    checkOutput("t2_tie1_sub_lat",  32'(lat1), 32'd6);
    checkOutput("t2_tie1_main_data", 32'(main_dout), 32'h5A);
    checkOutput("t2_tie1_sub_data",  32'(sub_dout),  32'h5A);
    applyStimulus(0, 1'b1, 13'h0004, 8'h11, lat, rd, ob);
    checkOutput("t2_lone_main_lat", 32'(lat), 32'd3);
    applyPair(1'b0, 13'h0004, 8'h00, 1'b0, 13'h0004, 8'h00, lat0, lat1);
    checkOutput("t2_tie2_sub_lat",  32'(lat1), 32'd3);
    checkOutput("t2_tie2_main_lat", 32'(lat0), 32'd6);
    checkOutput("t2_tie2_sub_data", 32'(sub_dout), 32'h11);

    $display("[TB] main write and sub read collide at 0x1FFF");
    applyStimulus(1, 1'b0, 13'h0004, 8'h00, lat, rd, ob);
    checkOutput("t3_pre_sub_data", 32'(rd), 32'h11);
    applyPair(1'b1, 13'h1FFF, 8'hA5, 1'b0, 13'h1FFF, 8'h00, lat0, lat1);
    checkOutput("t3_main_lat", 32'(lat0), 32'd3);
    checkOutput("t3_sub_lat",  32'(lat1), 32'd6);
    checkOutput("t3_sub_data", 32'(sub_dout), 32'hA5);

    $display("[TB] sub cs held for 20 cycles");
    drive(1, 1'b1, 1'b0, 13'h0C0A, 8'h00);
    #1;
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      if (sub_busy) highs++;
      step();
    end
    checkOutput("t4_first_highs", 32'(highs), 32'd3);
    checkOutput("t4_first_data", 32'(sub_dout), 32'h5A);
    applyStimulus(0, 1'b1, 13'h0C0A, 8'h99, lat, rd, ob);
    checkOutput("t4_main_wr_lat", 32'(lat), 32'd3);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      if (sub_busy) highs++;
      step();
    end
    checkOutput("t4_hold_highs", 32'(highs), 32'd0);
    checkOutput("t4_no_reread", 32'(sub_dout), 32'h5A);
    drive(1, 1'b0, 1'b0, 13'h0C0A, 8'h00);
    step();
    applyStimulus(1, 1'b0, 13'h0C0A, 8'h00, lat, rd, ob);
    checkOutput("t4_reraise_lat", 32'(lat), 32'd3);
    checkOutput("t4_reraise_data", 32'(rd), 32'h99);

    $display("[TB] reset during a main write");
    applyStimulus(0, 1'b1, 13'h0100, 8'h77, lat, rd, ob);
    applyStimulus(0, 1'b0, 13'h0100, 8'h00, lat, rd, ob);
    checkOutput("t5_pre_main_data", 32'(rd), 32'h77);
    drive(1, 1'b1, 1'b0, 13'h0100, 8'h00);
    #1;
    for (int i = 0; i < 8 && sub_busy; i++) step();
    checkOutput("t5_pre_sub_data", 32'(sub_dout), 32'h77);
    drive(0, 1'b1, 1'b1, 13'h0100, 8'h33);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 13'h0100, 8'h00);
    #1;
    checkOutput("t5_main_dout", 32'(main_dout), 32'h0);
    checkOutput("t5_sub_dout",  32'(sub_dout),  32'h0);
    checkOutput("t5_sub_done_cleared", 32'(sub_busy), 32'd1);
    checkOutput("t5_main_busy", 32'(main_busy), 32'd0);
    lat = 0;
    while (sub_busy && lat < 20) begin
      lat++;
      step();
    end
    checkOutput("t5_sub_lat", 32'(lat), 32'd3);
    checkOutput("t5_old_value", 32'(sub_dout), 32'h77);
    drive(1, 1'b0, 1'b0, 13'h0100, 8'h00);
    step();
    applyStimulus(0, 1'b0, 13'h0100, 8'h00, lat, rd, ob);
    checkOutput("t5_main_old_value", 32'(rd), 32'h77);

    $display("[TB] randomized two-port traffic");
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int p = 0; p < 2; p++) begin
      active[p] = 0; plat[p] = 0; held[p] = '0;
      we_r[p] = 0; addr_r[p] = '0; din_r[p] = '0;
    end
    ops = 0;
    cyc = 0;
    while (ops < 8192 && cyc < 60000) begin
      step();
      cyc++;
      for (int p = 0; p < 2; p++) begin
        if (active[p]) begin
          if (busy_of(p)) begin
            plat[p]++;
            if (plat[p] > 6) begin
              checkOutput("rnd_busy_timeout", 32'(plat[p]), 32'd6);
              active[p] = 0;
              drive(p, 1'b0, 1'b0, addr_r[p], din_r[p]);
            end
          end else begin
            checkOutput("rnd_latency_bound", 32'(plat[p] <= 6), 32'd1);
            if (we_r[p]) begin
              model_mem[addr_r[p]]   = din_r[p];
              model_known[addr_r[p]] = 1'b1;
              checkOutput("rnd_wr_dout_kept", 32'(dout_of(p)), 32'(held[p]));
            end else begin
              if (model_known[addr_r[p]])
                checkOutput("rnd_rd_data", 32'(dout_of(p)), 32'(model_mem[addr_r[p]]));
              else begin
                model_mem[addr_r[p]]   = dout_of(p);
                model_known[addr_r[p]] = 1'b1;
              end
              held[p] = model_mem[addr_r[p]];
            end
            ops++;
            active[p] = 0;
            drive(p, 1'b0, 1'($urandom_range(0, 1)), 13'($urandom_range(0, 8191)),
                  8'($urandom_range(0, 255)));
          end
        end else begin
          checkOutput("rnd_idle_busy", 32'(busy_of(p)), 32'd0);
          checkOutput("rnd_idle_dout", 32'(dout_of(p)), 32'(held[p]));
          if ($urandom_range(0, 2) == 0) begin
            we_r[p] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0)
              addr_r[p] = ($urandom_range(0, 1) == 0) ? 13'($urandom_range(0, 7))
                                                      : 13'($urandom_range(8184, 8191));
            else
              addr_r[p] = 13'($urandom_range(0, 8191));
            din_r[p]  = 8'($urandom_range(0, 255));
            plat[p]   = 1;
            active[p] = 1;
            drive(p, 1'b1, we_r[p], addr_r[p], din_r[p]);
          end else begin
            // Garbage on we/addr/din while cs is low must never reach the RAM.
            drive(p, 1'b0, 1'($urandom_range(0, 1)), 13'($urandom_range(0, 8191)),
                  8'($urandom_range(0, 255)));
          end
        end
      end
    end
    checkOutput("rnd_ops_completed", 32'(ops >= 8192), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
